bsg_asic_iodelay_input_cal: RTL and testbench

//  Receive-side deskew calibrator for one source-synchronous input channel (8 data bits + valid).

---
 rtl/bsg_asic_iodelay_pkg.sv | 20 ++
 rtl/bsg_asic_iodelay_input_window.sv | 63 ++++++
 rtl/bsg_asic_iodelay_input_cal.sv | 152 +++++++++++++++
 tb/tb_bsg_asic_iodelay_input_cal.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_asic_iodelay_pkg.sv
// Shared types and constants for the input delay calibration slice.
package bsg_asic_iodelay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        CENTER,
        DONE
    } state_e;

    // Training pattern sent by the far-end transmitter, alternating each cycle.
    localparam logic [7:0] train_a_c = 8'hA5;
    localparam logic [7:0] train_b_c = 8'h5A;

    function automatic int unsigned max_f(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bsg_asic_iodelay_input_window.sv
// Per-bit passing-window tracker: follows the current run of passing taps,
// keeps the longest one seen (lower tap wins ties) and reports its centre.
module bsg_asic_iodelay_input_window
    import bsg_asic_iodelay_pkg::*;
#(
    parameter int unsigned tap_width_p = 5,
    parameter int unsigned len_width_p = 6
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   clear_i,
    input  logic                   tap_done_i,
    input  logic                   pass_i,
    input  logic [tap_width_p-1:0] tap_i,
    output logic [tap_width_p-1:0] centre_o,
    output logic                   no_window_o
);

    logic [len_width_p-1:0] run_len_r;
    logic [len_width_p-1:0] best_len_r;
    logic [len_width_p-1:0] run_len_n;
    logic [len_width_p-1:0] half_len;
    logic [tap_width_p-1:0] run_start_r;
    logic [tap_width_p-1:0] best_start_r;
    logic [tap_width_p-1:0] run_start_n;

    // Candidate run after a passing tap; a fresh run starts at the current tap.
    always_comb begin
        run_len_n   = run_len_r + len_width_p'(1);
        run_start_n = (run_len_r == '0) ? tap_i : run_start_r;
    end

    // Run/best registers, updated once per swept tap.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            run_len_r    <= '0;
            run_start_r  <= '0;
            best_len_r   <= '0;
            best_start_r <= '0;
        end else if (clear_i) begin
            run_len_r    <= '0;
            run_start_r  <= '0;
            best_len_r   <= '0;
            best_start_r <= '0;
        end else if (tap_done_i) begin
            if (pass_i) begin
                run_len_r   <= run_len_n;
                run_start_r <= run_start_n;
                if (run_len_n > best_len_r) begin
                    best_len_r   <= run_len_n;
                    best_start_r <= run_start_n;
                end
            end else begin
                run_len_r <= '0;
            end
        end
    end

    assign no_window_o = (best_len_r == '0);
    assign half_len    = (best_len_r - len_width_p'(1)) >> 1;
    assign centre_o    = no_window_o ? '0 : best_start_r + tap_width_p'(half_len);

endmodule

// File: rtl/bsg_asic_iodelay_input_cal.sv
// Receive-side deskew calibrator: sweeps a shared tap over 8 data + valid
// delay elements, scores each tap against the training pattern, then programs
// every bit to the centre of its longest passing window.
module bsg_asic_iodelay_input_cal
    import bsg_asic_iodelay_pkg::*;
#(
    parameter int unsigned tap_width_p     = 5,
    parameter int unsigned tap_count_p     = 32,
    parameter int unsigned settle_cycles_p = 4,
    parameter int unsigned sample_cycles_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     start_i,
    input  logic [7:0]               data_i,
    input  logic                     valid_i,
    output logic [8*tap_width_p-1:0] data_tap_o,
    output logic [tap_width_p-1:0]   valid_tap_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [8:0]               fail_o
);

    localparam int unsigned cnt_w_lp =
        max_f(1, $clog2(max_f(settle_cycles_p, sample_cycles_p + 1)));
    localparam int unsigned len_w_lp = $clog2(tap_count_p + 1);

    state_e                 state_r;
    state_e                 state_n;
    logic [cnt_w_lp-1:0]    cnt_r;
    logic [tap_width_p-1:0] sweep_tap_r;
    logic [7:0]             prev_r;
    logic [8:0]             pass_acc_r;
    logic [8:0]             pass_now;
    logic                   settle_last;
    logic                   sample_last;
    logic                   tap_last;
    logic                   tap_done;
    logic                   start_ok;
    logic                   busy_r;
    logic                   done_r;
    logic [8:0]             fail_r;
    logic [tap_width_p-1:0] centre [9];
    logic [8:0]             no_window;

    assign settle_last = (cnt_r == cnt_w_lp'(settle_cycles_p - 1));
    assign sample_last = (cnt_r == cnt_w_lp'(sample_cycles_p));
    assign tap_last    = (sweep_tap_r == tap_width_p'(tap_count_p - 1));
    assign start_ok    = start_i && ((state_r == IDLE) || (state_r == DONE));
    assign tap_done    = (state_r == SAMPLE) && sample_last;

    // First SAMPLE cycle only captures the reference; valid is checked every cycle.
    assign pass_now = (cnt_r == '0) ? {valid_i, 8'hFF}
                                    : (pass_acc_r & {valid_i, data_i ^ prev_r});

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= IDLE;
        else            state_r <= state_n;
    end

    // Next-state logic: start is honoured only from IDLE or DONE.
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            IDLE, DONE: if (start_i)     state_n = SETTLE;
            SETTLE:     if (settle_last) state_n = SAMPLE;
            SAMPLE:     if (sample_last) state_n = tap_last ? CENTER : SETTLE;
            CENTER:                      state_n = DONE;
            default:                     state_n = IDLE;
        endcase
    end

    // Phase counter, sweep tap and per-tap pass accumulation.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r       <= '0;
            sweep_tap_r <= '0;
            prev_r      <= '0;
            pass_acc_r  <= '0;
        end else begin
            if (state_r != state_n)
                cnt_r <= '0;
            else if ((state_r == SETTLE) || (state_r == SAMPLE))
                cnt_r <= cnt_r + cnt_w_lp'(1);

            if (start_ok)
                sweep_tap_r <= '0;
            else if (tap_done && !tap_last)
                sweep_tap_r <= sweep_tap_r + tap_width_p'(1);

            if (state_r == SAMPLE) begin
                prev_r     <= data_i;
                pass_acc_r <= pass_now;
            end
        end
    end

    // Status flags are registered from the current state, so done_o/fail_o
    // rise one cycle after DONE is entered and fall one cycle after a restart.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            fail_r <= '0;
        end else begin
            busy_r <= (state_r == SETTLE) || (state_r == SAMPLE) || (state_r == CENTER);
            done_r <= (state_r == DONE);
            fail_r <= (state_r == DONE) ? no_window : '0;
        end
    end

    assign busy_o = busy_r;
    assign done_o = done_r;
    assign fail_o = fail_r;

    for (genvar b = 0; b < 9; b++) begin : g_win
        bsg_asic_iodelay_input_window #(
            .tap_width_p (tap_width_p),
            .len_width_p (len_w_lp)
        ) u_win (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .clear_i     (start_ok),
            .tap_done_i  (tap_done),
            .pass_i      (pass_now[b]),
            .tap_i       (sweep_tap_r),
            .centre_o    (centre[b]),
            .no_window_o (no_window[b])
        );
    end

    // Tap outputs: sweep tap while sweeping, window centres once computed.
    always_comb begin
        data_tap_o  = '0;
        valid_tap_o = '0;
        unique case (state_r)
            SETTLE, SAMPLE: begin
                for (int unsigned b = 0; b < 8; b++)
                    data_tap_o[b*tap_width_p +: tap_width_p] = sweep_tap_r;
                valid_tap_o = sweep_tap_r;
            end
            CENTER, DONE: begin
                for (int unsigned b = 0; b < 8; b++)
                    data_tap_o[b*tap_width_p +: tap_width_p] = centre[b];
                valid_tap_o = centre[8];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bsg_asic_iodelay_input_cal.sv
// Bench for the input delay calibrator: each delay element is a per-bit
// pass/fail map over tap; expected centres come from a window search on the maps.
module tb_bsg_asic_iodelay_input_cal;
    import bsg_asic_iodelay_pkg::*;

    localparam int TW = 5;

    logic            clk_i     = 1'b0;
    logic            reset_n_i = 1'b0;
    logic            start_i   = 1'b0;
    logic [7:0]      data_i    = '0;
    logic            valid_i   = 1'b0;
    logic [8*TW-1:0] data_tap_o;
    logic [TW-1:0]   valid_tap_o;
    logic            busy_o;
    logic            done_o;
    logic [8:0]      fail_o;

    bsg_asic_iodelay_input_cal #(
        .tap_width_p     (TW),
        .tap_count_p     (32),
        .settle_cycles_p (4),
        .sample_cycles_p (8)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .start_i     (start_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .data_tap_o  (data_tap_o),
        .valid_tap_o (valid_tap_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .fail_o      (fail_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    int unsigned edge_cnt = 0;
    int unsigned e0 = 0;

    logic [31:0] map [9];
    bit          glitch_en  = 1'b0;
    int          glitch_bit = 0;
    int          glitch_tap = 0;
    int unsigned glitch_n   = 0;
    logic        phase = 1'b0;
    logic [7:0]  d_drv = '0;

    // Edge counter used to time events relative to the accepted start edge.
    always @(posedge clk_i) edge_cnt++;

    // Delay-element model: a passing bit follows the training pattern, a failing
    // bit holds its last value (no toggle); valid reads 1 only when passing.
    always @(negedge clk_i) begin
        logic [7:0]  pat;
        logic        ok;
        int unsigned n;
        phase = ~phase;
        pat   = phase ? train_a_c : train_b_c;
        n     = edge_cnt - e0;
        for (int b = 0; b < 8; b++) begin
            ok = map[b][data_tap_o[b*TW +: TW]];
            if (glitch_en && b == glitch_bit && n == glitch_n) ok = 1'b0;
            if (ok) d_drv[b] = pat[b];
        end
        data_i  = d_drv;
        valid_i = map[8][valid_tap_o];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Longest run of passing taps, lowest start on ties, centre rounded down.
    function automatic void model(input logic [31:0] m, output logic [4:0] c, output logic f);
        int best_len;
        int best_s;
        int l;
        best_len = 0;
        best_s   = 0;
        for (int s = 0; s < 32; s++) begin
            l = 0;
            while (s + l < 32 && m[s + l]) l++;
            if (l > best_len) begin
                best_len = l;
                best_s   = s;
            end
        end
        f = (best_len == 0);
        c = f ? 5'd0 : 5'(best_s + (best_len - 1) / 2);
    endfunction

    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        e0      = edge_cnt;
        start_i = 1'b0;
    endtask

    task automatic set_glitch(input int b, input int t, input int s);
        glitch_en  = 1'b1;
        glitch_bit = b;
        glitch_tap = t;
        glitch_n   = 32'(t * 13 + 4 + s);
    endtask

    // Called 'elapsed' cycles after the start edge; checks done timing and results.
    task automatic run_check(input string tag, input int elapsed);
        logic [31:0] eff;
        logic [4:0]  c;
        logic        f;
        logic [8:0]  exp_fail;
        step(417 - elapsed);
        check({tag, "_done_early"}, 32'(done_o), 32'd0);
        step(1);
        check({tag, "_done"}, 32'(done_o), 32'd1);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        exp_fail = '0;
        for (int b = 0; b < 9; b++) begin
            eff = map[b];
            if (glitch_en && b == glitch_bit) eff[glitch_tap] = 1'b0;
            model(eff, c, f);
            exp_fail[b] = f;
            if (b < 8) check($sformatf("%s_tap%0d", tag, b), 32'(data_tap_o[b*TW +: TW]), 32'(c));
            else       check({tag, "_vtap"}, 32'(valid_tap_o), 32'(c));
        end
        check({tag, "_fail"}, 32'(fail_o), 32'(exp_fail));
    endtask

    task automatic all_pass();
        for (int b = 0; b < 9; b++) map[b] = '1;
        glitch_en = 1'b0;
    endtask

    task automatic rand_maps();
        logic [31:0] m;
        int k, s, l;
        for (int b = 0; b < 9; b++) begin
            m = '0;
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                s = $urandom_range(0, 31);
                l = $urandom_range(1, 14);
                for (int i = s; i < s + l && i < 32; i++) m[i] = 1'b1;
            end
            if ($urandom_range(0, 5) == 0) m = '1;
            map[b] = m;
        end
        glitch_en = 1'b0;
    endtask

    function automatic logic [31:0] range_map(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    initial begin
        all_pass();

        // Reset state.
        step(3);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_fail", 32'(fail_o), 32'd0);
        check("rst_dtap", 32'(data_tap_o), 32'd0);
        check("rst_vtap", 32'(valid_tap_o), 32'd0);
        reset_n_i = 1'b1;
        step(2);
        check("idle_tap", 32'(data_tap_o[3*TW +: TW]), 32'd0);

        // 1: bit3 passes 10..20, others all.
        all_pass();
        map[3] = range_map(10, 20);
        pulse_start();
        step(1);
        check("t1_busy", 32'(busy_o), 32'd1);
        run_check("t1", 1);
        check("t1_tap3_lit", 32'(data_tap_o[3*TW +: TW]), 32'd15);

        // 2: bit0 never passes, valid passes everywhere.
        all_pass();
        map[0] = '0;
        pulse_start();
        run_check("t2", 0);
        check("t2_fail_lit", 32'(fail_o), 32'h001);
        check("t2_vtap_lit", 32'(valid_tap_o), 32'd15);

        // 3: bit5 two windows (longer later one wins); bit6 equal windows (lower wins).
        all_pass();
        map[5] = range_map(2, 4) | range_map(20, 27);
        map[6] = range_map(2, 5) | range_map(20, 23);
        pulse_start();
        run_check("t3", 0);
        check("t3_tap5_lit", 32'(data_tap_o[5*TW +: TW]), 32'd23);
        check("t3_tap6_lit", 32'(data_tap_o[6*TW +: TW]), 32'd3);

        // 4: bit7 passes 6..9 but misses one toggle on the 3rd comparison at tap 8.
        all_pass();
        map[7] = range_map(6, 9);
        set_glitch(7, 8, 3);
        pulse_start();
        run_check("t4", 0);
        check("t4_tap7_lit", 32'(data_tap_o[7*TW +: TW]), 32'd6);
        glitch_en = 1'b0;

        // 5: reset mid-sweep, then ignored start pulses during a fresh sweep.
        rand_maps();
        pulse_start();
        step(199);
        check("t5_busy_pre", 32'(busy_o), 32'd1);
        reset_n_i = 1'b0;
        #1;
        check("t5_rst_dtap", 32'(data_tap_o), 32'd0);
        check("t5_rst_vtap", 32'(valid_tap_o), 32'd0);
        check("t5_rst_busy", 32'(busy_o), 32'd0);
        check("t5_rst_done", 32'(done_o), 32'd0);
        check("t5_rst_fail", 32'(fail_o), 32'd0);
        step(2);
        reset_n_i = 1'b1;
        step(1);
        pulse_start();
        step(50);
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        step(365);
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        run_check("t5", 417);
        step(1);
        check("t5_done_hold", 32'(done_o), 32'd1);

        // 6: restart from DONE with new maps; several randomized sweeps.
        for (int r = 0; r < 3; r++) begin
            rand_maps();
            pulse_start();
            step(1);
            check($sformatf("t6_%0d_done_drop", r), 32'(done_o), 32'd0);
            check($sformatf("t6_%0d_fail_drop", r), 32'(fail_o), 32'd0);
            check($sformatf("t6_%0d_busy", r), 32'(busy_o), 32'd1);
            run_check($sformatf("t6_%0d", r), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
